// File: rtl/hkspi_pkg.sv
// Shared types for the housekeeping SPI slave.
// Command mode codes, FSM states and count-field width.
package hkspi_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    MODE_NOP = 2'b00,
    MODE_RD  = 2'b01,
    MODE_WR  = 2'b10,
    MODE_RW  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_e;

endpackage

// File: rtl/hkspi_sync.sv
// Pad-input synchronizer with edge detection on the synchronized value.
// RST_VAL sets the idle level the chain assumes during reset.
module hkspi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= (chain << 1) | SYNC_STAGES'(din);
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/hkspi_slave.sv
// Housekeeping SPI slave: cmd/addr/data byte stream to a
// register bus, oversampled in the system clock domain.
module hkspi_slave
  import hkspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       sck,
  input  logic       csb,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata
);

  logic sck_q, sck_rise, sck_fall;
  logic csb_q, csb_rise, csb_fall;
  logic sdi_q, sdi_rise, sdi_fall;

  hkspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clock(clock), .resetb(resetb), .din(sck),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  hkspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb (
    .clock(clock), .resetb(resetb), .din(csb),
    .q(csb_q), .rise(csb_rise), .fall(csb_fall)
  );

  hkspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clock(clock), .resetb(resetb), .din(sdi),
    .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_q, csb_rise, sdi_rise, sdi_fall};

  state_e           state;
  mode_e            mode;
  logic [CNT_W-1:0] nbytes;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       tx;
  logic             first;
  logic             inc_pend;
  logic             rd_pend;
  logic             cap;
  logic             armed;
  logic [SYNC_STAGES:0] flush;

  logic [7:0] byte_in;
  logic       byte_done;
  logic       shifting;
  logic       last_byte;

  assign byte_in   = {shreg[6:0], sdi_q};
  assign shifting  = (state == CMD) || (state == ADDR) || (state == DATA);
  assign byte_done = sck_rise && shifting && (bit_cnt == 3'd7);
  assign last_byte = (nbytes != '0) &&
                     (CNT_W'(byte_cnt + 1'b1) == nbytes);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      mode      <= MODE_NOP;
      nbytes    <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      first     <= 1'b0;
      inc_pend  <= 1'b0;
      rd_pend   <= 1'b0;
      cap       <= 1'b0;
      armed     <= 1'b0;
      flush     <= '0;
      sdo       <= 1'b0;
      sdo_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
      // only trust csb high once the reset values have left the chain
      if (csb_q && flush[SYNC_STAGES])
        armed <= 1'b1;
      if (csb_q) begin
        state    <= IDLE;
        sdo      <= 1'b0;
        sdo_oe   <= 1'b0;
        first    <= 1'b0;
        inc_pend <= 1'b0;
        rd_pend  <= 1'b0;
        cap      <= 1'b0;
      end else begin
        cap <= reg_rd;
        if (cap) begin
          tx     <= reg_rdata;
          sdo_oe <= 1'b1;
          first  <= 1'b1;
        end
        if (inc_pend) begin
          reg_addr <= reg_addr + 8'd1;
          rd_pend  <= mode[0];
          inc_pend <= 1'b0;
        end
        if (rd_pend) begin
          reg_rd  <= 1'b1;
          rd_pend <= 1'b0;
        end
        if (sck_rise && shifting) begin
          shreg   <= byte_in;
          bit_cnt <= bit_cnt + 3'd1;
        end
        unique case (state)
          IDLE: begin
            if (armed && csb_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (byte_done) begin
              mode   <= mode_e'(byte_in[7:6]);
              nbytes <= byte_in[5:3];
              state  <= (byte_in[7:6] == MODE_NOP) ? DONE : ADDR;
            end
          end
          ADDR: begin
            if (byte_done) begin
              reg_addr <= byte_in;
              byte_cnt <= '0;
              rd_pend  <= mode[0];
              state    <= DATA;
            end
          end
          DATA: begin
            if (byte_done) begin
              if (mode[1]) begin
                reg_wr    <= 1'b1;
                reg_wdata <= byte_in;
              end
              byte_cnt <= CNT_W'(byte_cnt + 1'b1);
              if (last_byte) state <= DONE;
              else inc_pend <= 1'b1;
            end
            if (sck_fall && sdo_oe) begin
              sdo   <= first ? tx[7] : tx[6];
              first <= 1'b0;
              if (!first) tx <= tx << 1;
            end
          end
          DONE: sdo <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/hkspi_slave.md
HKSPI_SLAVE -- requirements
Module: hkspi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sck/csb/sdi.
REQ-002 SHALL have port clock, input, 1: system clock; the only clock, and all logic is in this domain.
REQ-003 SHALL have port resetb, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port sck, input, 1: SPI clock from the pad; asynchronous to clock.
REQ-005 SHALL have port csb, input, 1: SPI chip select, active low; asynchronous.
REQ-006 SHALL have port sdi, input, 1: SPI serial data in; asynchronous.
REQ-007 SHALL have port sdo, output, 1: SPI serial data out.
REQ-008 SHALL have port sdo_oe, output, 1: sdo output enable, active high.
REQ-009 SHALL have port reg_addr, output, 8: register address.
REQ-010 SHALL have port reg_wdata, output, 8: write data, valid while reg_wr=1.
REQ-011 SHALL have port reg_wr, output, 1: single-cycle write strobe.
REQ-012 SHALL have port reg_rd, output, 1: single-cycle read request.
REQ-013 SHALL have port reg_rdata, input, 8: read data; valid on the cycle after reg_rd.

Function
REQ-014 SHALL pass sck, csb and sdi through SYNC_STAGES flops each, then detect sck rise/fall edges on the synchronized signal.
REQ-015 SHALL sample sdi MSB-first on each detected sck rise; SPI mode 0.
REQ-016 SHALL implement states IDLE, CMD, ADDR, DATA, DONE.
REQ-017 SHALL go IDLE->CMD on synchronized csb falling.
REQ-018 SHALL go CMD->ADDR after 8 bits.
REQ-019 SHALL go ADDR->DATA after 8 bits.
REQ-020 SHALL go DATA->DONE when the byte count is exhausted.
REQ-021 SHALL go from any state to IDLE on synchronized csb high.
REQ-022 SHALL decode command byte bits [7:6] as the mode: 00 no-op, 10 write stream, 01 read stream, 11 read/write stream.
REQ-023 SHALL decode command byte bits [5:3] as the byte count N: N=0 means unlimited, N=1..7 means exactly N data bytes then DONE.
REQ-024 SHALL, for no-op mode, enter DONE directly after CMD and issue no strobes.
REQ-025 SHALL latch the address byte into reg_addr on the 8th address bit.
REQ-026 SHALL, in read modes, pulse reg_rd 1 cycle after the address latch, capture reg_rdata 1 cycle later into the tx shifter, then assert sdo_oe.
REQ-027 SHALL drive sdo MSB of the tx shifter from the first sck fall after the load, and shift left on each later sck fall.
REQ-028 SHALL, on data byte completion in write modes, set reg_wdata and pulse reg_wr for 1 cycle with the current reg_addr.
REQ-029 SHALL increment reg_addr the cycle after data byte completion, wrapping 0xFF->0x00.
REQ-030 SHALL, in read modes, issue the next reg_rd for the incremented address after that increment.
REQ-031 SHALL, in read/write mode, write the old address first, then read the new address.
REQ-032 SHALL discard a partial byte on csb rising: no reg_wr, no reg_rd, sdo_oe=0 within 1 cycle of synchronized csb high.
REQ-033 SHALL ignore sck edges in IDLE and DONE; in DONE sdo holds 0 and no strobes are issued.
REQ-034 SHALL guarantee correct operation when sck high and low phases are each >= SYNC_STAGES+3 clock periods; faster sck is undefined.
REQ-035 SHALL never assert reg_wr and reg_rd in the same cycle.

Reset
REQ-036 SHALL, while resetb=0, force state IDLE and reset all outputs to 0: sdo, sdo_oe, reg_addr, reg_wdata, reg_wr, reg_rd.
REQ-037 SHALL reset the synchronizer flops to sck=0, csb=1, sdi=0.
REQ-038 SHALL, when reset is asserted mid-transfer, abort with no strobes; after release it waits for a fresh csb falling edge.

Structure
REQ-039 SHALL place the mode codes (NOP, WR, RD, RW), the state enum and the count-field width in shared package hkspi_pkg.
REQ-040 SHALL implement synchronizer plus edge detect as sub-module hkspi_sync, instantiated 3 times, with SYNC_STAGES passed down.

Verification
REQ-041 SHALL cover read stream: 0x40, 0x03, 1 byte with reg_rdata=0x11 at addr 3 -> exactly 1 reg_rd at addr 0x03, sdo byte 0x11.
REQ-042 SHALL cover write stream: 0x80, 0x0B, 0x01 -> exactly 1 reg_wr, addr 0x0B, wdata 0x01, sdo_oe stays 0.
REQ-043 SHALL cover streaming read: 0x40, 0x00, 19 bytes -> reg_rd at addrs 0x00..0x12 in order, each sdo byte equal to the model value.
REQ-044 SHALL cover wrap and count: 0x88 (write, N=1), 0xFF, 0xAA, 0x55 -> one reg_wr at 0xFF with data 0xAA; 0x55 ignored; then 0x80, 0xFF, 2 bytes -> writes at 0xFF then 0x00.
REQ-045 SHALL cover abort: csb raised after 5 bits of a write data byte -> no reg_wr; sdo_oe=0; the next transfer decodes correctly.
REQ-046 SHALL cover reset: resetb pulsed low mid-read -> all outputs 0 within 1 cycle, no strobes until a new csb falling edge.
